// File: rtl/fir_pkg.sv
// Shared sizing helpers for the AXI-Stream FIR filter.
package fir_pkg;

    // Ceiling log2; returns the number of bits needed to index 'value' entries.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Full-precision width of one coefficient * sample product.
    function automatic int prod_width(input int data_w, input int coeff_w);
        return data_w + coeff_w;
    endfunction

    // Accumulator width wide enough that summing every tap cannot overflow.
    function automatic int sum_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + clog2(taps);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up arithmetic right shift followed by signed saturation.
module fir_round_sat #(
    parameter int IN_WIDTH  = 37,
    parameter int OUT_SHIFT = 15,
    parameter int OUT_WIDTH = 16
) (
    input  logic [IN_WIDTH-1:0]  din,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 sat
);

    // One guard bit keeps the rounding add from overflowing.
    localparam int RW = IN_WIDTH + 1;

    localparam logic signed [RW-1:0] MAX_VAL = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_VAL = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] rnd;

    assign ext = {din[IN_WIDTH-1], din};

    if (OUT_SHIFT == 0) begin : g_bypass
        assign rnd = ext;
    end else begin : g_round
        localparam logic signed [RW-1:0] HALF = RW'(1) << (OUT_SHIFT - 1);
        assign rnd = (ext + HALF) >>> OUT_SHIFT;
    end

    // Clamp to the signed output range and flag when clamping happened.
    always_comb begin
        dout = rnd[OUT_WIDTH-1:0];
        sat  = 1'b0;
        if (rnd > MAX_VAL) begin
            dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            sat  = 1'b1;
        end else if (rnd < MIN_VAL) begin
            dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_filter_axis.sv
// Direct-form FIR filter with AXI-Stream in/out and writable coefficients.
// Pipeline: delay line -> product registers -> rounded/saturated output reg.
// The whole pipeline advances together on en, so a stalled output freezes it.
module fir_filter_axis
    import fir_pkg::*;
#(
    parameter int NUM_TAPS    = 31,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int OUT_WIDTH   = 16,
    parameter int OUT_SHIFT   = 15
) (
    input  logic                         aclk,
    input  logic                         rst_ni,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [OUT_WIDTH-1:0]         m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    input  logic                         coeff_we_i,
    input  logic [clog2(NUM_TAPS)-1:0]   coeff_addr_i,
    input  logic [COEFF_WIDTH-1:0]       coeff_data_i,
    input  logic                         clear_i,
    output logic                         sat_o
);

    localparam int AW = clog2(NUM_TAPS);
    localparam int PW = prod_width(DATA_WIDTH, COEFF_WIDTH);
    localparam int SW = sum_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);

    logic                          en;
    logic signed [COEFF_WIDTH-1:0] coeff [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]  dly   [NUM_TAPS];
    logic signed [PW-1:0]          prod  [NUM_TAPS];
    logic                          dly_valid, dly_last;
    logic                          prod_valid, prod_last;
    logic signed [SW-1:0]          sum;
    logic [OUT_WIDTH-1:0]          rs_data;
    logic                          rs_sat;

    assign en            = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = en;

    // Coefficient file: writes land regardless of stalls; out-of-range addresses drop.
    always_ff @(posedge aclk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_TAPS; k++) coeff[k] <= '0;
        end else if (coeff_we_i && ({1'b0, coeff_addr_i} < (AW+1)'(NUM_TAPS))) begin
            coeff[coeff_addr_i] <= coeff_data_i;
        end
    end

    // Stage 0: sample delay line, shifts only when a beat is accepted.
    always_ff @(posedge aclk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_TAPS; k++) dly[k] <= '0;
            dly_valid <= 1'b0;
            dly_last  <= 1'b0;
        end else if (clear_i) begin
            for (int k = 0; k < NUM_TAPS; k++) dly[k] <= '0;
            dly_valid <= 1'b0;
            dly_last  <= 1'b0;
        end else if (en) begin
            dly_valid <= s_axis_tvalid;
            dly_last  <= s_axis_tvalid & s_axis_tlast;
            if (s_axis_tvalid) begin
                dly[0] <= s_axis_tdata;
                for (int k = 1; k < NUM_TAPS; k++) dly[k] <= dly[k-1];
            end
        end
    end

    // Stage 1: full-precision per-tap products.
    always_ff @(posedge aclk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_TAPS; k++) prod[k] <= '0;
            prod_valid <= 1'b0;
            prod_last  <= 1'b0;
        end else if (clear_i) begin
            for (int k = 0; k < NUM_TAPS; k++) prod[k] <= '0;
            prod_valid <= 1'b0;
            prod_last  <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < NUM_TAPS; k++) prod[k] <= PW'(coeff[k]) * PW'(dly[k]);
            prod_valid <= dly_valid;
            prod_last  <= dly_last;
        end
    end

    // Stage 2 adder tree; width is sized so the sum never wraps.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_TAPS; k++) sum = sum + SW'(prod[k]);
    end

    fir_round_sat #(
        .IN_WIDTH  (SW),
        .OUT_SHIFT (OUT_SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_round_sat (
        .din  (sum),
        .dout (rs_data),
        .sat  (rs_sat)
    );

    // Output register: holds while the downstream side stalls.
    always_ff @(posedge aclk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            sat_o         <= 1'b0;
        end else if (clear_i) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            sat_o         <= 1'b0;
        end else if (en) begin
            m_axis_tdata  <= rs_data;
            m_axis_tvalid <= prod_valid;
            m_axis_tlast  <= prod_last;
            sat_o         <= prod_valid & rs_sat;
        end
    end

endmodule

// File: tb/tb_fir_filter_axis.sv
// Bench for fir_filter_axis: two instances (OUT_SHIFT 0 and 1) share one stimulus
// stream; a golden model scores every output beat, and directed tables cover
// impulse, rounding, saturation, tlast, clear, backpressure and reset.
module tb_fir_filter_axis;

    logic        aclk = 1'b0;
    logic        rst_ni;
    logic [15:0] s_tdata;
    logic        s_tvalid, s_tlast, m_tready;
    logic        coeff_we, clear;
    logic [4:0]  coeff_addr;
    logic [15:0] coeff_data;

    logic        s_tready0, s_tready1;
    logic [15:0] m_tdata0, m_tdata1;
    logic        m_tvalid0, m_tvalid1, m_tlast0, m_tlast1, sat0, sat1;

    always #5 aclk = ~aclk;

    fir_filter_axis #(.NUM_TAPS(31), .DATA_WIDTH(16), .COEFF_WIDTH(16), .OUT_WIDTH(16), .OUT_SHIFT(0)) u_s0 (
        .aclk(aclk), .rst_ni(rst_ni),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready0),
        .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tlast(m_tlast0), .m_axis_tready(m_tready),
        .coeff_we_i(coeff_we), .coeff_addr_i(coeff_addr), .coeff_data_i(coeff_data),
        .clear_i(clear), .sat_o(sat0));

    fir_filter_axis #(.NUM_TAPS(31), .DATA_WIDTH(16), .COEFF_WIDTH(16), .OUT_WIDTH(16), .OUT_SHIFT(1)) u_s1 (
        .aclk(aclk), .rst_ni(rst_ni),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready1),
        .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1), .m_axis_tlast(m_tlast1), .m_axis_tready(m_tready),
        .coeff_we_i(coeff_we), .coeff_addr_i(coeff_addr), .coeff_data_i(coeff_data),
        .clear_i(clear), .sat_o(sat1));

    typedef struct { longint sum; bit last; } sb_t;
    typedef struct { longint d0; bit s0; longint d1; bit s1; bit l; } beat_t;
    typedef struct { longint x; bit clr; longint e0; bit sat0; longint e1; bit sat1; } vec_t;

    sb_t    sbq[$];
    beat_t  capq[$];
    longint xm[31];
    longint cm[31];
    int     total = 0;
    int     bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic void ref_rs(input longint s, input int sh, output longint d, output bit sat);
        longint r;
        if (sh == 0) r = s;
        else r = (s + (longint'(1) <<< (sh - 1))) >>> sh;
        sat = 1'b1;
        if (r > 32767) d = 32767;
        else if (r < -32768) d = -32768;
        else begin
            d   = r;
            sat = 1'b0;
        end
    endfunction

    // Scoreboard: score any beat leaving the DUT, then model any beat entering it.
    always @(negedge aclk) begin : mon
        beat_t  b;
        sb_t    e;
        longint d;
        bit     s;
        longint acc;
        if (!rst_ni) begin
            sbq.delete();
            for (int k = 0; k < 31; k++) begin
                xm[k] = 0;
                cm[k] = 0;
            end
        end else begin
            if (m_tvalid0 && m_tready) begin
                b.d0 = longint'($signed(m_tdata0));
                b.s0 = sat0;
                b.d1 = longint'($signed(m_tdata1));
                b.s1 = sat1;
                b.l  = m_tlast0;
                capq.push_back(b);
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_beat", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    ref_rs(e.sum, 0, d, s);
                    chk("sb_data_s0", b.d0, d);
                    chk("sb_sat_s0", b.s0, s);
                    ref_rs(e.sum, 1, d, s);
                    chk("sb_data_s1", b.d1, d);
                    chk("sb_sat_s1", b.s1, s);
                    chk("sb_last", b.l, e.last);
                    chk("sb_valid_s1", m_tvalid1, 1);
                end
            end
            if (clear) begin
                sbq.delete();
                for (int k = 0; k < 31; k++) xm[k] = 0;
            end else if (s_tvalid && s_tready0) begin
                for (int k = 30; k > 0; k--) xm[k] = xm[k-1];
                xm[0] = longint'($signed(s_tdata));
                acc = 0;
                for (int k = 0; k < 31; k++) acc += cm[k] * xm[k];
                e.sum  = acc;
                e.last = s_tlast;
                sbq.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) step();
    endtask

    task automatic wcoef(input int a, input longint v);
        coeff_we   = 1'b1;
        coeff_addr = 5'(a);
        coeff_data = 16'(v);
        if (a < 31) cm[a] = v;
        step();
        coeff_we = 1'b0;
    endtask

    task automatic send(input longint x, input bit last);
        bit acc;
        int g;
        s_tvalid = 1'b1;
        s_tdata  = 16'(x);
        s_tlast  = last;
        g = 0;
        do begin
            acc = s_tready0;
            step();
            g++;
        end while (!acc && g < 100);
        if (!acc) chk("send_timeout", 0, 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (capq.size() < n && t < 200) begin
            step();
            t++;
        end
        if (capq.size() < n) chk("beat_timeout", capq.size(), n);
    endtask

    task automatic check_impulse(input int n, input bit all_zero);
        longint exp;
        chk("imp_count", capq.size(), n);
        for (int i = 0; i < capq.size(); i++) begin
            exp = (all_zero || i >= 31) ? 0 : i + 1;
            chk("imp_data", capq[i].d0, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        beat_t b;
        if (v.clr) begin
            clear = 1'b1;
            step();
            clear = 1'b0;
        end
        capq.delete();
        send(v.x, 1'b0);
        wait_beats(1);
        if (capq.size() > 0) begin
            b = capq.pop_front();
            chk("vec_data_s0", b.d0, v.e0);
            chk("vec_sat_s0", b.s0, v.sat0);
            chk("vec_data_s1", b.d1, v.e1);
            chk("vec_sat_s1", b.s1, v.sat1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        vec_t   vt[7];
        int     c, sent;
        bit     acc;
        longint held;

        // rounding (b0=1, others 0): shift0 passes through, shift1 rounds half up
        vt[0] = '{x: 3,      clr: 0, e0: 3,      sat0: 0, e1: 2,      sat1: 0};
        vt[1] = '{x: -3,     clr: 0, e0: -3,     sat0: 0, e1: -1,     sat1: 0};
        vt[2] = '{x: 2,      clr: 0, e0: 2,      sat0: 0, e1: 1,      sat1: 0};
        // saturation (all b=32767)
        vt[3] = '{x: 32767,  clr: 1, e0: 32767,  sat0: 1, e1: 32767,  sat1: 1};
        vt[4] = '{x: 32767,  clr: 0, e0: 32767,  sat0: 1, e1: 32767,  sat1: 1};
        vt[5] = '{x: -32768, clr: 1, e0: -32768, sat0: 1, e1: -32768, sat1: 1};
        vt[6] = '{x: -32768, clr: 0, e0: -32768, sat0: 1, e1: -32768, sat1: 1};

        rst_ni     = 1'b0;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        m_tready   = 1'b1;
        coeff_we   = 1'b0;
        coeff_addr = '0;
        coeff_data = '0;
        clear      = 1'b0;
        repeat (3) step();
        rst_ni = 1'b1;
        step();

        chk("rst_m_tvalid", m_tvalid0, 0);
        chk("rst_m_tdata", m_tdata0, 0);
        chk("rst_m_tlast", m_tlast0, 0);
        chk("rst_sat", sat0, 0);
        chk("rst_s_tready", s_tready0, 1);

        for (int k = 0; k < 31; k++) wcoef(k, k + 1);
        wcoef(31, 999);

        // impulse with latency check: accepted at edge N, valid after N+2
        capq.delete();
        s_tvalid = 1'b1;
        s_tdata  = 16'd1;
        chk("imp_s_tready", s_tready0, 1);
        step();
        chk("lat_after_n", m_tvalid0, 0);
        s_tdata = 16'd0;
        step();
        chk("lat_after_n1", m_tvalid0, 0);
        step();
        chk("lat_after_n2", m_tvalid0, 1);
        chk("lat_first_data", longint'($signed(m_tdata0)), 1);
        for (int i = 0; i < 38; i++) send(0, 1'b0);
        idle(6);
        check_impulse(41, 1'b0);

        // backpressure: ramp stream with a 5-cycle output stall
        capq.delete();
        sent = 0;
        c    = 0;
        held = 0;
        while (sent < 25 && c < 200) begin
            m_tready = !(c >= 6 && c < 11);
            s_tvalid = 1'b1;
            s_tdata  = 16'(sent * 3 - 20);
            #1;
            acc = s_tready0;
            if (c == 6) held = longint'($signed(m_tdata0));
            if (c > 6 && c < 11) begin
                chk("bp_s_tready", s_tready0, 0);
                chk("bp_m_tvalid", m_tvalid0, 1);
                chk("bp_data_hold", longint'($signed(m_tdata0)), held);
            end
            step();
            if (acc) sent++;
            c++;
        end
        m_tready = 1'b1;
        idle(8);
        chk("bp_beats", capq.size(), 25);
        chk("bp_sb_empty", sbq.size(), 0);

        // rounding table
        wcoef(0, 1);
        for (int k = 1; k < 31; k++) wcoef(k, 0);
        for (int i = 0; i < 3; i++) apply_vec(vt[i]);

        // saturation table
        for (int k = 0; k < 31; k++) wcoef(k, 32767);
        for (int i = 3; i < 7; i++) apply_vec(vt[i]);
        idle(4);

        // tlast on the 10th sample only
        for (int k = 0; k < 31; k++) wcoef(k, k + 1);
        capq.delete();
        for (int i = 0; i < 12; i++) send(i + 1, i == 9);
        idle(6);
        chk("tlast_beats", capq.size(), 12);
        for (int i = 0; i < capq.size(); i++) chk("tlast_bit", capq[i].l, (i == 9));

        // clear with samples still in flight, then impulse must show no residue
        capq.delete();
        send(5, 1'b0);
        send(6, 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        idle(5);
        chk("clear_no_beats", capq.size(), 0);
        send(1, 1'b0);
        for (int i = 0; i < 35; i++) send(0, 1'b0);
        idle(6);
        check_impulse(36, 1'b0);

        // reset mid-stream
        capq.delete();
        for (int i = 0; i < 5; i++) send(i + 1, 1'b0);
        chk("rst_mid_pre_valid", m_tvalid0, 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_valid", m_tvalid0, 0);
        chk("rst_mid_s_tready", s_tready0, 1);
        capq.delete();
        step();
        rst_ni = 1'b1;
        idle(4);
        chk("rst_mid_no_beats", capq.size(), 0);
        send(1, 1'b0);
        for (int i = 0; i < 35; i++) send(0, 1'b0);
        idle(6);
        check_impulse(36, 1'b1);

        chk("final_sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_filter_axis.md
FIR_FILTER_AXIS -- requirements
Module: fir_filter_axis

Interface
REQ-001 Parameter NUM_TAPS, default 31, number of coefficients/taps (range 2..64).
REQ-002 Parameter DATA_WIDTH, default 16, signed input sample width.
REQ-003 Parameter COEFF_WIDTH, default 16, signed coefficient width.
REQ-004 Parameter OUT_WIDTH, default 16, signed output sample width.
REQ-005 Parameter OUT_SHIFT, default 15, arithmetic right shift applied to the full-precision sum before rounding.
REQ-006 aclk  in  1  single clock; all logic rising-edge.
REQ-007 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-008 s_axis_tdata  in  DATA_WIDTH  signed input sample.
REQ-009 s_axis_tvalid / s_axis_tlast  in  1 each  AXI-Stream slave valid/last.
REQ-010 s_axis_tready  out  1  slave ready.
REQ-011 m_axis_tdata  out  OUT_WIDTH  signed filtered sample, registered.
REQ-012 m_axis_tvalid / m_axis_tlast  out  1 each  master valid/last, registered.
REQ-013 m_axis_tready  in  1  master ready.
REQ-014 coeff_we_i  in  1  coefficient write strobe.
REQ-015 coeff_addr_i  in  clog2(NUM_TAPS)  tap index k (coefficient b[k] multiplies x[n-k]).
REQ-016 coeff_data_i  in  COEFF_WIDTH  signed coefficient value.
REQ-017 clear_i  in  1  synchronous flush of delay line and pipeline; coefficients retained.
REQ-018 sat_o  out  1  asserted with an output beat whose value was saturated.

Function
REQ-019 Pipeline enable en = ~m_axis_tvalid | m_axis_tready; s_axis_tready SHALL equal en (combinational, no dependency on s_axis_tvalid).
REQ-020 Stage 0: on s_axis_tvalid & en, delay line shifts x[0]<=s_axis_tdata, x[k]<=x[k-1]; no shift otherwise.
REQ-021 Stage 1 (on en): product registers p[k]<=b[k]*x[k], full width DATA_WIDTH+COEFF_WIDTH, with valid/last tag.
REQ-022 Stage 2 (on en): sum of all p[k] at width DATA_WIDTH+COEFF_WIDTH+clog2(NUM_TAPS), no overflow possible.
REQ-023 Rounding: result = (sum + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (round half up); OUT_SHIFT=0 bypasses rounding.
REQ-024 Saturation: result outside OUT_WIDTH signed range clamps to max/min; sat_o=1 for that beat.
REQ-025 Latency: with m_axis_tready=1, output for a sample accepted at edge N appears valid after edge N+2.
REQ-026 m_axis_tlast SHALL accompany the output beat of the sample that carried s_axis_tlast; tlast does not reset the delay line.
REQ-027 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tlast/sat_o and all pipeline stages SHALL hold stable.
REQ-028 Bubbles (en=1, no input beat) propagate as invalid; m_axis_tvalid drops if no valid stage feeds it.
REQ-029 Coefficient write updates b[coeff_addr_i] at the next edge, independent of en; an address >= NUM_TAPS is ignored.
REQ-030 A coefficient written at edge N is used by any stage-1 product captured at edge N+1 or later.
REQ-031 clear_i has priority over data: delay line, products, valid tags, m_axis_tvalid, m_axis_tlast, sat_o cleared at the next edge.

Reset
REQ-032 rst_ni=0 SHALL asynchronously clear delay line, products, sum, all valid/last tags, m_axis_tdata, m_axis_tvalid, m_axis_tlast, sat_o to 0.
REQ-033 Coefficients reset to 0; s_axis_tready=1 after reset release (output empty).
REQ-034 Reset mid-stream discards all in-flight samples; no partial beat is emitted after release.

Structure
REQ-035 Package fir_pkg holds the clog2 function and sum-width/product-width derivation constants.
REQ-036 Sub-module fir_round_sat implements REQ-023/REQ-024 (combinational, parametrised by input width, OUT_SHIFT, OUT_WIDTH).

Verification (NUM_TAPS=31, widths 16)
REQ-037 Impulse: OUT_SHIFT=0, b[k]=k+1, input 1 then 40 zeros, tready=1 -> outputs 1,2,...,31 then 0, first at edge N+2.
REQ-038 Backpressure: stream ramp, hold m_axis_tready=0 for 5 cycles -> s_axis_tready=0, m_axis_tdata constant, no samples lost or duplicated vs golden model.
REQ-039 Saturation: OUT_SHIFT=0, all b=32767, inputs 32767 -> m_axis_tdata=32767, sat_o=1; inputs -32768 -> -32768, sat_o=1.
REQ-040 Rounding: OUT_SHIFT=1, b[0]=1, others 0; inputs 3, -3, 2 -> outputs 2, -1, 1, sat_o=0.
REQ-041 tlast/clear: tlast on 10th sample -> m_axis_tlast on 10th output only; clear_i then impulse -> no residue from prior samples.
REQ-042 Reset mid-stream: rst_ni low for 1 cycle while m_axis_tvalid=1 -> m_axis_tvalid=0 immediately, coefficients read back as 0 via impulse output of all zeros.
